// File: rtl/etarget_pkg.sv
// Shared types and register-map constants for the time-of-arrival capture block.
package etarget_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } toa_state_t;

    localparam int DEFAULT_CNT_W = 16;

    // Byte offsets seen by the I2C register file.
    localparam logic [7:0] REG_HIT          = 8'h00;
    localparam logic [7:0] REG_TIMEOUT      = 8'h01;
    localparam logic [7:0] REG_COUNT_BASE   = 8'h02;
    localparam logic [7:0] REG_COUNT_STRIDE = 8'h02;

endpackage

// File: rtl/toa_edge_sync.sv
// Synchronises one asynchronous mic comparator input and flags its 0->1 transitions.
module toa_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mic_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], mic_i};

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/toa_capture.sv
// N-channel time-of-arrival capture: waits for a first hit, then latches each
// channel's arrival on a shared tick-driven timebase until all hit or timeout.
module toa_capture
    import etarget_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [N_CH-1:0]       mic,
    input  logic                  arm,
    input  logic                  clear,
    input  logic                  sw_start,
    output logic [1:0]            state_o,
    output logic [N_CH-1:0]       hit,
    output logic [N_CH*CNT_W-1:0] count,
    output logic                  timeout,
    output logic                  irq
);

    localparam logic [CNT_W-1:0] MAX_T = {CNT_W{1'b1}};

    toa_state_t             state_q, state_d;
    logic [CNT_W-1:0]       tb_q, tb_d;
    logic [N_CH-1:0]        hit_q, hit_d;
    logic [N_CH*CNT_W-1:0]  count_q, count_d;
    logic                   timeout_q, timeout_d;
    logic                   irq_q, irq_d;
    logic [N_CH-1:0]        rise_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        toa_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .mic_i   (mic[g]),
            .rise_o  (rise_s[g])
        );
    end

    // Next-state, timebase and per-channel latch logic.
    always_comb begin
        state_d   = state_q;
        tb_d      = tb_q;
        hit_d     = hit_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        irq_d     = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            tb_d      = '0;
            hit_d     = '0;
            count_d   = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_d   = ARMED;
                        tb_d      = '0;
                        hit_d     = '0;
                        count_d   = '0;
                        timeout_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ARMED: begin
                    // The first hit defines time zero; tick is not counted on this edge.
                    if ((|rise_s) || sw_start) begin
                        tb_d    = '0;
                        hit_d   = rise_s;
                        count_d = '0;
                        if (&rise_s) begin
                            state_d = DONE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = ARMED;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (rise_s[i] && !hit_q[i]) begin
                            hit_d[i]                   = 1'b1;
                            count_d[i*CNT_W +: CNT_W]  = tb_q;
                        end else begin
                            hit_d[i] = hit_q[i];
                        end
                    end
                    if (tick && (tb_q == MAX_T)) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                        irq_d     = 1'b1;
                    end else begin
                        if (tick) begin
                            tb_d = tb_q + 1'b1;
                        end else begin
                            tb_d = tb_q;
                        end
                        if (&hit_d) begin
                            state_d = DONE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tb_q      <= '0;
            hit_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tb_q      <= tb_d;
            hit_q     <= hit_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end

    assign state_o = state_q;
    assign hit     = hit_q;
    assign count   = count_q;
    assign timeout = timeout_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_toa_capture.sv
// Directed and randomized checks of toa_capture against a rule-level reference model.
module tb_toa_capture;
    import etarget_pkg::*;

    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int MAXT = 255;

    logic          clk = 1'b0;
    logic          reset_n, tick, arm, clear, sw_start;
    logic [NC-1:0] mic;
    logic [1:0]    state_o;
    logic [NC-1:0] hit;
    logic [NC*CW-1:0] count;
    logic          timeout, irq;

    toa_capture #(.N_CH(NC), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .mic(mic), .arm(arm),
        .clear(clear), .sw_start(sw_start), .state_o(state_o), .hit(hit),
        .count(count), .timeout(timeout), .irq(irq)
    );

    always #5 clk = ~clk;

    // reference model
    toa_state_t m_state;
    int         m_t;
    logic [3:0] m_hit;
    int         m_cnt [NC];
    logic       m_to, m_irq;
    logic [3:0] d1, d2, d3;

    int checks = 0;
    int errors = 0;
    int tick_mode = 0;
    int cyc = 0;
    int irq_seen = 0;
    int dly [NC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_count_vec();
        logic [31:0] v;
        for (int c = 0; c < NC; c++) v[c*CW +: CW] = m_cnt[c][CW-1:0];
        return v;
    endfunction

    task automatic m_zero();
        m_t = 0; m_hit = 4'h0; m_to = 1'b0;
        for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    endtask

    task automatic model_reset();
        m_state = IDLE; m_zero(); m_irq = 1'b0;
        d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    endtask

    // A pin change reaches the capture logic as a rise two edges after it is sampled.
    task automatic model_edge(input logic tk);
        logic [3:0] rise;
        rise = d2 & ~d3;
        d3 = d2; d2 = d1; d1 = mic;
        m_irq = 1'b0;
        if (clear) begin
            m_state = IDLE; m_zero();
        end else if (m_state == IDLE || m_state == DONE) begin
            if (arm) begin m_state = ARMED; m_zero(); end
        end else if (m_state == ARMED) begin
            if (rise != 4'h0 || sw_start) begin
                m_zero(); m_hit = rise; m_state = RUN;
                if (rise == 4'hF) begin m_state = DONE; m_irq = 1'b1; end
            end
        end else begin
            for (int c = 0; c < NC; c++)
                if (rise[c] && !m_hit[c]) begin m_hit[c] = 1'b1; m_cnt[c] = m_t; end
            if (tk && m_t == MAXT) begin
                m_to = 1'b1; m_state = DONE; m_irq = 1'b1;
            end else begin
                if (tk) m_t++;
                if (m_hit == 4'hF) begin m_state = DONE; m_irq = 1'b1; end
            end
        end
    endtask

    task automatic step();
        case (tick_mode)
            0: tick = 1'b0;
            1: tick = 1'b1;
            8: tick = (cyc % 8 == 0);
            default: tick = ($urandom_range(0, 1) == 1);
        endcase
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge(tick);
        cyc++;
        @(negedge clk);
        if (irq) irq_seen++;
        chk("state", state_o, m_state);
        chk("hit", hit, m_hit);
        chk("count", count, m_count_vec());
        chk("timeout", timeout, m_to);
        chk("irq", irq, m_irq);
        arm = 1'b0; clear = 1'b0; sw_start = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_state(input toa_state_t s, input int bound, input string tag);
        for (int k = 0; k < bound && m_state != s; k++) step();
        chk(tag, state_o, s);
    endtask

    task automatic wait_t(input int target);
        for (int k = 0; k < 4000 && m_t != target; k++) step();
        chk("wait_t", m_t, target);
    endtask

    task automatic flush();
        mic = 4'h0; clear = 1'b1; step(); steps(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0; arm = 1'b0; clear = 1'b0; sw_start = 1'b0; mic = 4'h0;
        model_reset();
        @(negedge clk);
        steps(3);
        chk("rst_state", state_o, IDLE);
        chk("rst_count", count, 32'h0);
        reset_n = 1'b1;
        steps(2);

        // 1: staggered arrivals at 0/10/25/40 ticks
        tick_mode = 8; flush(); irq_seen = 0;
        arm = 1'b1; step();
        mic[0] = 1'b1; wait_state(RUN, 10, "t1_run");
        wait_t(10); mic[1] = 1'b1;
        wait_t(25); mic[2] = 1'b1;
        wait_t(40); mic[3] = 1'b1;
        wait_state(DONE, 10, "t1_done");
        steps(4);
        chk("t1_count", count, 32'h28190A00);
        chk("t1_hit", hit, 4'hF);
        chk("t1_irq_once", irq_seen, 1);

        // 2: mic1/mic3 together, then mic0/mic2 within one tick period
        flush(); arm = 1'b1; step();
        mic = 4'b1010; wait_state(RUN, 10, "t2_run");
        wait_t(7); mic[0] = 1'b1; step(); mic[2] = 1'b1;
        wait_state(DONE, 20, "t2_done");
        chk("t2_c1", count[15:8], 8'd0);
        chk("t2_c3", count[31:24], 8'd0);
        chk("t2_c0", count[7:0], 8'd7);
        chk("t2_c2", count[23:16], 8'd7);

        // 3: single channel, timebase runs out
        tick_mode = 1; flush(); arm = 1'b1; step();
        mic[2] = 1'b1;
        wait_state(DONE, 400, "t3_done");
        chk("t3_timeout", timeout, 1'b1);
        chk("t3_hit", hit, 4'h4);
        chk("t3_count", count, 32'h0);

        // 4: level-high mic must not trigger
        tick_mode = 8; flush(); mic[0] = 1'b1; steps(5);
        arm = 1'b1; step(); steps(10);
        chk("t4_armed", state_o, ARMED);
        mic[0] = 1'b0; steps(4); mic[0] = 1'b1;
        wait_state(RUN, 10, "t4_run");
        chk("t4_hit", hit, 4'h1);

        // 5: software start, then all mics together
        flush(); arm = 1'b1; step();
        sw_start = 1'b1; step();
        chk("t5_run", state_o, RUN);
        chk("t5_hit", hit, 4'h0);
        wait_t(5); mic = 4'hF;
        wait_state(DONE, 10, "t5_done");
        chk("t5_count", count, 32'h05050505);

        // 6: clear beats arm; reset mid-run
        flush(); arm = 1'b1; step();
        mic[1] = 1'b1; wait_state(RUN, 10, "t6_run");
        wait_t(3); mic[2] = 1'b1; steps(4);
        clear = 1'b1; arm = 1'b1; step();
        chk("t6_idle", state_o, IDLE);
        chk("t6_hit", hit, 4'h0);
        flush(); arm = 1'b1; step();
        mic[0] = 1'b1; wait_state(RUN, 10, "t6_run2");
        wait_t(2); mic[1] = 1'b1; steps(3);
        irq_seen = 0;
        #2 reset_n = 1'b0; mic = 4'h0; #1;
        chk("t6_rst_state", state_o, IDLE);
        chk("t6_rst_hit", hit, 4'h0);
        chk("t6_rst_count", count, 32'h0);
        @(negedge clk); model_reset(); steps(3);
        reset_n = 1'b1; steps(5);
        chk("t6_no_irq", irq_seen, 0);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            tick_mode = 2; flush();
            for (int c = 0; c < NC; c++) begin
                dly[c] = $urandom_range(0, 120);
                if (c != 0 && $urandom_range(0, 3) == 0) dly[c] = 99999;
            end
            arm = 1'b1; step();
            if ($urandom_range(0, 2) == 0) sw_start = 1'b1;
            for (int k = 0; k < 700 && m_state != DONE; k++) begin
                for (int c = 0; c < NC; c++) mic[c] = (k >= dly[c]);
                if (k == dly[0] + 2 && $urandom_range(0, 1) == 1) mic[0] = 1'b0;
                if (m_state != DONE && $urandom_range(0, 49) == 0) arm = 1'b1;
                step();
            end
            chk("rnd_done", state_o, DONE);
            steps(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
